// File: rtl/hsr_board_reset_ctrl.sv
// Board bring-up sequencer for HSR FPGA tops: synchronises lock and reset switch,
// releases the PHY resets one after another, then releases the core once the PHYs settle.
module hsr_board_reset_ctrl #(
  parameter int NUM_PHY       = 3,
  parameter int DEBOUNCE_CYC  = 1250000,
  parameter int PHY_RST_CYC   = 1250000,
  parameter int STAGGER_CYC   = 125,
  parameter int PHY_WAIT_CYC  = 625000,
  parameter int HEARTBEAT_CYC = 31250000
) (
  input  logic               gtx_clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               board_rst_sw,
  input  logic               hsr_ready,
  input  logic [2:0]         conf_led,
  output logic [NUM_PHY-1:0] phy_reset_n,
  output logic               sys_reset_n,
  output logic [NUM_PHY-1:0] phy_ready,
  output logic [7:0]         restart_cnt,
  output logic [7:0]         board_led
);

  localparam int SEQ_MAX_A = (PHY_RST_CYC > STAGGER_CYC) ? PHY_RST_CYC : STAGGER_CYC;
  localparam int SEQ_MAX   = (SEQ_MAX_A > PHY_WAIT_CYC) ? SEQ_MAX_A : PHY_WAIT_CYC;
  localparam int CW        = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
  localparam int DW        = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HW        = (HEARTBEAT_CYC > 1) ? $clog2(HEARTBEAT_CYC) : 1;
  localparam int IW        = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic               lock_meta_q, lock_s_q, lock_prev_q;
  logic               sw_meta_q, sw_s_q;
  logic               sw_db_q, sw_db_d;
  logic [DW-1:0]      db_cnt_q, db_cnt_d;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_PHY-1:0] phy_rst_q, phy_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic [NUM_PHY-1:0] phy_rdy_q, phy_rdy_d;
  logic [7:0]         restart_q, restart_d;
  logic               sticky_q, sticky_d;
  logic               seen_run_q, seen_run_d;
  logic               hb_q, hb_d;
  logic [HW-1:0]      hb_cnt_q, hb_cnt_d;
  logic [7:0]         led_q, led_d;
  logic               fault, lock_fall, sw_db_rise;

  // Debounce: the counter only runs while the synced switch disagrees with sw_db.
  always_comb begin
    sw_db_d  = sw_db_q;
    db_cnt_d = '0;
    if (sw_s_q != sw_db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYC - 1)) sw_db_d = sw_s_q;
      else db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  assign fault      = ~lock_s_q | sw_db_q;
  assign lock_fall  = lock_prev_q & ~lock_s_q;
  assign sw_db_rise = sw_db_d & ~sw_db_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    phy_rst_d = phy_rst_q;
    if (fault) begin
      state_d   = ST_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      phy_rst_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == CW'(PHY_RST_CYC - 1)) begin
            state_d      = ST_RELEASE;
            cnt_d        = '0;
            idx_d        = '0;
            phy_rst_d    = '0;
            phy_rst_d[0] = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (idx_q == IW'(NUM_PHY - 1)) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(STAGGER_CYC - 1)) begin
            // Released PHYs form a contiguous run of ones from bit 0; extend it by one.
            cnt_d     = '0;
            idx_d     = idx_q + IW'(1);
            phy_rst_d = phy_rst_q | (phy_rst_q << 1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CW'(PHY_WAIT_CYC - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sys_rst_d  = (state_d == ST_RUN);
    phy_rdy_d  = {NUM_PHY{state_d == ST_RUN}};
    seen_run_d = seen_run_q | (state_q == ST_RUN);
    restart_d  = restart_q;
    if ((state_q != ST_HOLD) && (state_d == ST_HOLD) && (restart_q != 8'hFF))
      restart_d = restart_q + 8'd1;
    sticky_d = sticky_q;
    if (sw_db_rise) sticky_d = 1'b0;
    if (lock_fall && ((state_q != ST_HOLD) || seen_run_q)) sticky_d = 1'b1;
    // Heartbeat restarts from zero on the RUN entry edge.
    hb_d     = 1'b0;
    hb_cnt_d = '0;
    if ((state_d == ST_RUN) && (state_q == ST_RUN)) begin
      hb_d = hb_q;
      if (hb_cnt_q == HW'(HEARTBEAT_CYC - 1)) hb_d = ~hb_q;
      else hb_cnt_d = hb_cnt_q + HW'(1);
    end
    led_d = {state_d, sticky_d, hb_d, conf_led, hsr_ready & sys_rst_d};
  end

  always_ff @(posedge gtx_clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      lock_prev_q <= 1'b0;
      sw_meta_q   <= 1'b0;
      sw_s_q      <= 1'b0;
      sw_db_q     <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      phy_rst_q   <= '0;
      sys_rst_q   <= 1'b0;
      phy_rdy_q   <= '0;
      restart_q   <= 8'd0;
      sticky_q    <= 1'b0;
      seen_run_q  <= 1'b0;
      hb_q        <= 1'b0;
      hb_cnt_q    <= '0;
      led_q       <= 8'd0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
      lock_prev_q <= lock_s_q;
      sw_meta_q   <= board_rst_sw;
      sw_s_q      <= sw_meta_q;
      sw_db_q     <= sw_db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      phy_rst_q   <= phy_rst_d;
      sys_rst_q   <= sys_rst_d;
      phy_rdy_q   <= phy_rdy_d;
      restart_q   <= restart_d;
      sticky_q    <= sticky_d;
      seen_run_q  <= seen_run_d;
      hb_q        <= hb_d;
      hb_cnt_q    <= hb_cnt_d;
      led_q       <= led_d;
    end
  end

  assign phy_reset_n = phy_rst_q;
  assign sys_reset_n = sys_rst_q;
  assign phy_ready   = phy_rdy_q;
  assign restart_cnt = restart_q;
  assign board_led   = led_q;

endmodule

// File: tb/tb_hsr_board_reset_ctrl.sv
// Directed bench for hsr_board_reset_ctrl with short timing parameters; expected
// values are hand-derived cycle counts relative to reset release or PHY0 release.
module tb_hsr_board_reset_ctrl;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       board_rst_sw;
  logic       hsr_ready;
  logic [2:0] conf_led;
  logic [2:0] phy_reset_n;
  logic       sys_reset_n;
  logic [2:0] phy_ready;
  logic [7:0] restart_cnt;
  logic [7:0] board_led;

  int vec_cnt;
  int err_cnt;
  int exp_restart;
  logic [14:0] exp_q[$];

  hsr_board_reset_ctrl #(
    .NUM_PHY(3), .DEBOUNCE_CYC(4), .PHY_RST_CYC(10),
    .STAGGER_CYC(3), .PHY_WAIT_CYC(5), .HEARTBEAT_CYC(8)
  ) dut (
    .gtx_clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .board_rst_sw(board_rst_sw), .hsr_ready(hsr_ready), .conf_led(conf_led),
    .phy_reset_n(phy_reset_n), .sys_reset_n(sys_reset_n), .phy_ready(phy_ready),
    .restart_cnt(restart_cnt), .board_led(board_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phy0(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      seen = phy_reset_n[0];
    end
    vec_cnt++;
    if (!seen) begin
      err_cnt++;
      $display("FAIL %s: phy_reset_n[0] got 0 within 100 cycles, required 1", tag);
    end
  endtask

  // From the PHY0 release edge: PHY1 +3, PHY2 +6, SETTLE +7, RUN/sys_reset_n +12.
  task automatic check_release_seq(input string tag);
    logic [9:0] exp_v, act_v;
    logic       sys_e;
    logic [1:0] st_e;
    wait_phy0(tag);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) step();
      sys_e = (k >= 12);
      st_e  = (k < 7) ? 2'd1 : (k < 12) ? 2'd2 : 2'd3;
      exp_v = {(k >= 6), (k >= 3), 1'b1, sys_e, {3{sys_e}}, st_e, sys_e};
      act_v = {phy_reset_n, sys_reset_n, phy_ready, board_led[7:6], board_led[0]};
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL %s k=%0d: got %b required %b", tag, k, act_v, exp_v);
      end
    end
  endtask

  task automatic press_switch(input int len);
    board_rst_sw = 1'b1;
    repeat (len) step();
    board_rst_sw = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    vec_cnt++;
    if (phy_reset_n !== 3'b000) begin err_cnt++; $display("FAIL reset_phy: got %b required 000", phy_reset_n); end
    vec_cnt++;
    if (sys_reset_n !== 1'b0) begin err_cnt++; $display("FAIL reset_sys: got %b required 0", sys_reset_n); end
    vec_cnt++;
    if (phy_ready !== 3'b000) begin err_cnt++; $display("FAIL reset_ready: got %b required 000", phy_ready); end
    vec_cnt++;
    if (restart_cnt !== 8'd0) begin err_cnt++; $display("FAIL reset_restart: got %0d required 0", restart_cnt); end
    vec_cnt++;
    if (board_led !== 8'd0) begin err_cnt++; $display("FAIL reset_led: got %b required 00000000", board_led); end
  endtask

  // Cycle k counts edges after reset release: 2 sync + 10 hold puts PHY0 at k=12.
  task automatic test_power_up();
    logic [14:0] exp_v, act_v;
    logic [1:0]  st_e;
    logic        sys_e, hb_e;
    for (int k = 1; k <= 45; k++) begin
      sys_e = (k >= 24);
      st_e  = (k < 12) ? 2'd0 : (k < 19) ? 2'd1 : (k < 24) ? 2'd2 : 2'd3;
      hb_e  = (k >= 24) ? (((k - 24) / 8) % 2 == 1) : 1'b0;
      exp_q.push_back({(k >= 18), (k >= 15), (k >= 12), sys_e, {3{sys_e}},
                       st_e, 1'b0, hb_e, 3'b101, sys_e});
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      exp_v = exp_q.pop_front();
      act_v = {phy_reset_n, sys_reset_n, phy_ready, board_led};
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL power_up k=%0d: got %b required %b", k, act_v, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    logic [21:0] act_v;
    board_rst_sw = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 2) board_rst_sw = 1'b0;
      act_v = {phy_reset_n, sys_reset_n, phy_ready, restart_cnt, board_led[7:5], board_led[3:0]};
      vec_cnt++;
      if (act_v !== {3'b111, 1'b1, 3'b111, 8'd0, 3'b110, 4'b1011}) begin
        err_cnt++;
        $display("FAIL glitch i=%0d: got %b required %b", i, act_v,
                 {3'b111, 1'b1, 3'b111, 8'd0, 3'b110, 4'b1011});
      end
    end
  endtask

  task automatic test_switch_reset();
    press_switch(6);
    exp_restart = 1;
    vec_cnt++;
    if ({phy_reset_n, sys_reset_n, phy_ready, board_led[7:6], board_led[4]} !== 10'd0) begin
      err_cnt++;
      $display("FAIL switch_hold: got %b required 0000000000",
               {phy_reset_n, sys_reset_n, phy_ready, board_led[7:6], board_led[4]});
    end
    vec_cnt++;
    if (restart_cnt !== 8'(exp_restart)) begin
      err_cnt++;
      $display("FAIL switch_restart: got %0d required %0d", restart_cnt, exp_restart);
    end
    check_release_seq("switch_seq");
  endtask

  task automatic test_lock_loss();
    press_switch(6);
    exp_restart++;
    wait_phy0("lock_loss_wait");
    step();
    pll_locked = 1'b0;
    repeat (3) step();
    exp_restart++;
    vec_cnt++;
    if (phy_reset_n !== 3'b000) begin err_cnt++; $display("FAIL lock_loss_phy: got %b required 000", phy_reset_n); end
    vec_cnt++;
    if (board_led[7:5] !== 3'b001) begin err_cnt++; $display("FAIL lock_loss_led: got %b required 001", board_led[7:5]); end
    vec_cnt++;
    if (restart_cnt !== 8'(exp_restart)) begin
      err_cnt++;
      $display("FAIL lock_loss_restart: got %0d required %0d", restart_cnt, exp_restart);
    end
    pll_locked = 1'b1;
    check_release_seq("relock_seq");
    vec_cnt++;
    if (board_led[5] !== 1'b1) begin err_cnt++; $display("FAIL sticky_hold: got %b required 1", board_led[5]); end
  endtask

  task automatic test_sticky_clear();
    press_switch(6);
    exp_restart++;
    vec_cnt++;
    if (board_led[5] !== 1'b0) begin err_cnt++; $display("FAIL sticky_clear: got %b required 0", board_led[5]); end
    vec_cnt++;
    if (restart_cnt !== 8'(exp_restart)) begin
      err_cnt++;
      $display("FAIL sticky_restart: got %0d required %0d", restart_cnt, exp_restart);
    end
    check_release_seq("post_clear_seq");
  endtask

  task automatic test_restart_sat();
    for (int n = 0; n < 260; n++) begin
      pll_locked = 1'b1;
      wait_phy0("sat_wait");
      pll_locked = 1'b0;
      repeat (4) step();
      exp_restart = (exp_restart < 255) ? exp_restart + 1 : 255;
      vec_cnt++;
      if (restart_cnt !== 8'(exp_restart)) begin
        err_cnt++;
        $display("FAIL restart_sat n=%0d: got %0d required %0d", n, restart_cnt, exp_restart);
      end
    end
    vec_cnt++;
    if (restart_cnt !== 8'd255) begin err_cnt++; $display("FAIL restart_final: got %0d required 255", restart_cnt); end
  endtask

  task automatic test_async_reset();
    bit seen;
    pll_locked = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      seen = (board_led[7:6] == 2'd2);
    end
    vec_cnt++;
    if (!seen) begin err_cnt++; $display("FAIL settle_wait: state never reached 2 within 100 cycles"); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vec_cnt++;
    if ({phy_reset_n, sys_reset_n, phy_ready, restart_cnt, board_led} !== 23'd0) begin
      err_cnt++;
      $display("FAIL async_reset: got %b required all zero",
               {phy_reset_n, sys_reset_n, phy_ready, restart_cnt, board_led});
    end
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    vec_cnt      = 0;
    err_cnt      = 0;
    exp_restart  = 0;
    reset_n      = 1'b0;
    pll_locked   = 1'b1;
    board_rst_sw = 1'b0;
    hsr_ready    = 1'b1;
    conf_led     = 3'b101;
    test_reset();
    test_power_up();
    test_glitch();
    test_switch_reset();
    test_lock_loss();
    test_sticky_clear();
    test_restart_sat();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
